// File: rtl/ula_nbit_seq.sv
// ula_nbit_seq: N-bit MIPS-style ALU with a registered result and a valid/ready
// handshake. AND/OR/ADD/SUB/SLT/NOR complete in one cycle. MUL is an iterative
// unsigned shift-add that takes WIDTH cycles.
module ula_nbit_seq #(
   parameter int WIDTH  = 32,
   parameter bit MUL_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       ctl,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             overflow,
   output logic             cout
);

   localparam int CNT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               ovf_q, ovf_d;
   logic               cout_q, cout_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [2*WIDTH-1:0] prod_q, prod_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic               ainv, binv;
   logic [WIDTH-1:0]   a_eff, b_eff;
   logic [WIDTH:0]     sum_w;
   logic               c_msb_in, alu_ovf, alu_cout;
   logic [WIDTH-1:0]   alu_res;
   logic               alu_ovf_o, alu_cout_o;
   logic               is_mul, accept;
   logic [WIDTH:0]     mul_add;
   logic [2*WIDTH-1:0] prod_step;

   assign ainv = ctl[3];
   assign binv = ctl[2];

   // Single-cycle ALU: shared adder on optionally inverted operands, then op decode.
   always_comb begin
      a_eff      = ainv ? ~a : a;
      b_eff      = binv ? ~b : b;
      sum_w      = {1'b0, a_eff} + {1'b0, b_eff} + {{WIDTH{1'b0}}, binv};
      alu_cout   = sum_w[WIDTH];
      // Carry into the MSB recovered from the MSB sum bit and its operands.
      c_msb_in   = a_eff[WIDTH-1] ^ b_eff[WIDTH-1] ^ sum_w[WIDTH-1];
      alu_ovf    = c_msb_in ^ alu_cout;
      alu_res    = '0;
      alu_ovf_o  = 1'b0;
      alu_cout_o = 1'b0;
      case (ctl)
         4'b0000: alu_res = a & b;
         4'b0001: alu_res = a | b;
         4'b1100: alu_res = a_eff & b_eff;
         4'b0010, 4'b0110: begin
            alu_res    = sum_w[WIDTH-1:0];
            alu_ovf_o  = alu_ovf;
            alu_cout_o = alu_cout;
         end
         4'b0111: begin
            // Sign of the difference, corrected when the subtraction overflowed.
            alu_res    = {{(WIDTH-1){1'b0}}, sum_w[WIDTH-1] ^ alu_ovf};
            alu_ovf_o  = alu_ovf;
            alu_cout_o = alu_cout;
         end
         default: ;
      endcase
   end

   // One shift-add multiply step: conditionally add multiplicand to the high half, shift right.
   always_comb begin
      mul_add   = prod_q[0] ? ({1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q})
                            : {1'b0, prod_q[2*WIDTH-1:WIDTH]};
      prod_step = {mul_add, prod_q[WIDTH-1:1]};
   end

   assign is_mul    = MUL_EN && (ctl == 4'b0011);
   assign in_ready  = rst_n & ((state_q == S_IDLE) | ((state_q == S_DONE) & out_ready));
   assign accept    = in_valid & in_ready;
   assign out_valid = (state_q == S_DONE);
   assign result    = result_q;
   assign zero      = out_valid & ~(|result_q);
   assign overflow  = ovf_q;
   assign cout      = cout_q;

   // Next-state and datapath update for the IDLE/BUSY/DONE handshake FSM.
   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      ovf_d    = ovf_q;
      cout_d   = cout_q;
      mcand_d  = mcand_q;
      prod_d   = prod_q;
      cnt_d    = cnt_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (accept) begin
               if (is_mul) begin
                  state_d = S_BUSY;
                  mcand_d = a;
                  prod_d  = {{WIDTH{1'b0}}, b};
                  cnt_d   = '0;
               end else begin
                  state_d  = S_DONE;
                  result_d = alu_res;
                  ovf_d    = alu_ovf_o;
                  cout_d   = alu_cout_o;
               end
            end else if (state_q == S_DONE && out_ready) begin
               state_d = S_IDLE;
            end
         end
         S_BUSY: begin
            prod_d = prod_step;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d  = S_DONE;
               result_d = prod_step[WIDTH-1:0];
               ovf_d    = |prod_step[2*WIDTH-1:WIDTH];
               cout_d   = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Control state and visible outputs, cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         result_q <= '0;
         ovf_q    <= 1'b0;
         cout_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         ovf_q    <= ovf_d;
         cout_q   <= cout_d;
      end
   end

   // Multiplier working registers; only meaningful while BUSY, so not reset.
   always_ff @(posedge clk) begin
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
   end

endmodule
